// File: rtl/tx_scheduler_pkg.sv
// rtl/tx_scheduler_pkg.sv - shared state encoding and byte width for tx_scheduler
// Purpose: constants and types shared by the scheduler top, its interface and bench.
// Ports: none (package).
package tx_scheduler_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_IDLE = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

endpackage

// File: rtl/tx_scheduler_if.sv
// rtl/tx_scheduler_if.sv - requester and transmitter signal bundle for tx_scheduler
// Purpose: groups the requester handshake and the transmitter drive signals.
// Signals:
//   req_valid [N_REQ]      per-requester byte-available flag
//   req_data  [8*N_REQ]    per-requester byte, requester i in [8i+7:8i]
//   req_ready [N_REQ]      one-hot accept strobe
//   tx_send               send strobe to the transmitter
//   tx_data   [8]         byte to the transmitter
//   busy                  high whenever the scheduler is not idle
//   grant_id  [clog2(N)]  index of the last accepted requester
// Modports: master = requester/observer side, slave = scheduler side.
interface tx_scheduler_if
  import tx_scheduler_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_send;
  logic [BYTE_W-1:0]       tx_data;
  logic                    busy;
  logic [IW-1:0]           grant_id;

  modport master (
    output req_valid, req_data,
    input  req_ready, tx_send, tx_data, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx_send, tx_data, busy, grant_id
  );

endinterface

// File: rtl/tx_scheduler_rr_arbiter.sv
// rtl/tx_scheduler_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first asserted request at or above the pointer, wrapping
//          modulo N_REQ (works for non-power-of-2 N_REQ).
// Ports:
//   req       [N_REQ]      request vector
//   ptr       [clog2(N)]   highest-priority index
//   grant     [N_REQ]      one-hot grant (zero when no request)
//   grant_idx [clog2(N)]   index of the granted request
//   any_grant             at least one request present
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any_grant
);

  int            idx;
  logic [IW-1:0] idx_w;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Explicit wrap rather than a modulo so non-power-of-2 sizes stay in range.
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = IW'(idx);
      if (!any_grant && req[idx_w]) begin
        any_grant    = 1'b1;
        grant[idx_w] = 1'b1;
        grant_idx    = idx_w;
      end
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - round-robin sharing of one serial byte transmitter
// Purpose: accepts one byte per frame from N_REQ producers, drives the
//          transmitter send/data inputs and times frame occupancy itself,
//          since the transmitter exposes no busy flag.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   tx_scheduler_if.slave: req_valid/req_data in, req_ready,
//         tx_send, tx_data, busy, grant_id out
module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 12,
  parameter int GAP_CYCLES   = 1
) (
  input  logic          clk,
  input  logic          rst,
  tx_scheduler_if.slave bus
);

  localparam int IW          = $clog2(N_REQ);
  localparam int HOLD_CYCLES = FRAME_CYCLES + GAP_CYCLES;
  localparam int CW          = $clog2(HOLD_CYCLES + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     ptr;
  logic [N_REQ-1:0]  grant;
  logic [IW-1:0]     win_idx;
  logic              any_grant;
  logic              take;
  logic [BYTE_W-1:0] req_bytes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_bytes[i] = bus.req_data[BYTE_W*i +: BYTE_W];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (win_idx),
    .any_grant (any_grant)
  );

  // Ready depends only on state, valid and pointer; data is sampled on take.
  assign take          = (state == ST_IDLE) && any_grant;
  assign bus.req_ready = (state == ST_IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_HOLD;
      cnt          <= '0;
      ptr          <= '0;
      bus.tx_send  <= 1'b0;
      bus.tx_data  <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b1;
    end else begin
      case (state)
        // The transmitter is not reset with us; wait out any frame in flight.
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt      <= '0;
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (take) begin
            bus.tx_data  <= req_bytes[win_idx];
            bus.grant_id <= win_idx;
            ptr          <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            bus.tx_send  <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          bus.tx_send <= 1'b0;
          cnt         <= WAIT_LOAD;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            cnt   <= GAP_LOAD;
            state <= ST_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // tx_send stays low here so the transmitter sees a clean next edge.
        ST_GAP: begin
          if (cnt == '0) begin
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          cnt         <= '0;
          bus.tx_send <= 1'b0;
          bus.busy    <= 1'b1;
          state       <= ST_HOLD;
        end
      endcase
    end
  end

endmodule
